// File: rtl/convolution_seq_if.sv
// Bus bundle for the convolution issue sequencer: control inputs, memory/accumulator strobes, status.
// All strobes (rd_x, acc_en, wr_z, done) are valid-only: there is no ready, and the receiver must act on every cycle the strobe is high.
interface convolution_seq_if #(
    parameter int ADDRW = 5
);
    logic             start;
    logic             abort;
    logic [ADDRW:0]   size_x;
    logic [ADDRW:0]   size_y;
    logic [ADDRW-1:0] addr_x;
    logic [ADDRW-1:0] addr_y;
    logic             rd_x;
    logic             acc_en;
    logic             acc_first;
    logic             wr_z;
    logic [ADDRW:0]   addr_z;
    logic             busy;
    logic             done;
    // FSM state for observation: 0 IDLE, 1 RUN, 2 DRAIN, 3 DONE
    logic [1:0]       state_dbg;

    modport master (
        output start, abort, size_x, size_y,
        input  addr_x, addr_y, rd_x, acc_en, acc_first, wr_z, addr_z, busy, done, state_dbg
    );

    modport slave (
        input  start, abort, size_x, size_y,
        output addr_x, addr_y, rd_x, acc_en, acc_first, wr_z, addr_z, busy, done, state_dbg
    );
endinterface

// File: rtl/convolution_seq.sv
// Issue-side sequencer for Z[n] = sum_k X[k]*Y[n-k]: walks every (n,k) term at one per cycle,
// drives X/Y read addresses, the accumulator enable/clear and the Z write strobe.
module convolution_seq #(
    parameter int ADDRW  = 5,
    parameter int RD_LAT = 1
) (
    input logic              clk,
    input logic              rstn,
    convolution_seq_if.slave bus
);
    localparam int EW = ADDRW + 2;
    localparam logic [EW-1:0] ONE = EW'(1);
    localparam logic [EW-1:0] TWO = EW'(2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [ADDRW:0] sx_q, sy_q;
    logic [EW-1:0]  n_q, k_q;
    logic           first_q;

    // Issue tags travel RD_LAT stages so acc_en lines up with read data
    logic [RD_LAT-1:0] p_v, p_first, p_last, p_final;
    logic [ADDRW:0]    p_n [RD_LAT];

    logic           wr_q, wr_final_q;
    logic [ADDRW:0] addr_z_q;

    logic [EW-1:0] sx_e, sy_e, last_n, kmax, n_inc, kmin_next;
    logic          k_is_max, final_term, issue, start_ok, zero_size, kill;

    always_comb begin
        sx_e       = EW'(sx_q);
        sy_e       = EW'(sy_q);
        last_n     = sx_e + sy_e - TWO;
        kmax       = (n_q < sx_e - ONE) ? n_q : sx_e - ONE;
        k_is_max   = (k_q == kmax);
        final_term = k_is_max && (n_q == last_n);
        n_inc      = n_q + ONE;
        // lowest k of the next output: max(0, n+1-size_y+1)
        kmin_next  = (n_inc >= sy_e) ? n_inc - sy_e + ONE : '0;
        issue      = (state_q == S_RUN);
        start_ok   = bus.start && !bus.abort;
        zero_size  = (bus.size_x == '0) || (bus.size_y == '0);
        kill       = bus.abort && (state_q != S_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = zero_size ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (final_term) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (wr_q && wr_final_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Term walker; counters freeze on the final term so addresses hold afterwards
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sx_q    <= '0;
            sy_q    <= '0;
            n_q     <= '0;
            k_q     <= '0;
            first_q <= 1'b0;
        end else if (state_q == S_IDLE) begin
            if (start_ok && !zero_size) begin
                sx_q    <= bus.size_x;
                sy_q    <= bus.size_y;
                n_q     <= '0;
                k_q     <= '0;
                first_q <= 1'b1;
            end
        end else if (issue && !bus.abort && !final_term) begin
            if (k_is_max) begin
                n_q     <= n_inc;
                k_q     <= kmin_next;
                first_q <= 1'b1;
            end else begin
                k_q     <= k_q + ONE;
                first_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p_v        <= '0;
            p_first    <= '0;
            p_last     <= '0;
            p_final    <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                p_n[i] <= '0;
            end
            wr_q       <= 1'b0;
            wr_final_q <= 1'b0;
            addr_z_q   <= '0;
        end else if (kill) begin
            p_v        <= '0;
            wr_q       <= 1'b0;
            wr_final_q <= 1'b0;
        end else begin
            p_v[0]     <= issue;
            p_first[0] <= first_q;
            p_last[0]  <= k_is_max;
            p_final[0] <= final_term;
            p_n[0]     <= n_q[ADDRW:0];
            for (int i = 1; i < RD_LAT; i++) begin
                p_v[i]     <= p_v[i-1];
                p_first[i] <= p_first[i-1];
                p_last[i]  <= p_last[i-1];
                p_final[i] <= p_final[i-1];
                p_n[i]     <= p_n[i-1];
            end
            // Z[n] is final the cycle after its highest-k term accumulates
            wr_q       <= p_v[RD_LAT-1] && p_last[RD_LAT-1];
            wr_final_q <= p_v[RD_LAT-1] && p_final[RD_LAT-1];
            if (p_v[RD_LAT-1] && p_last[RD_LAT-1]) begin
                addr_z_q <= p_n[RD_LAT-1];
            end
        end
    end

    assign bus.rd_x      = issue;
    assign bus.addr_x    = k_q[ADDRW-1:0];
    assign bus.addr_y    = ADDRW'(n_q - k_q);
    assign bus.acc_en    = p_v[RD_LAT-1];
    assign bus.acc_first = p_v[RD_LAT-1] && p_first[RD_LAT-1];
    assign bus.wr_z      = wr_q;
    assign bus.addr_z    = addr_z_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_convolution_seq.sv
// Bench for convolution_seq: X/Y memories and accumulator modelled around the DUT, expected
// issue order and Z values computed directly from the convolution definition.
module tb_convolution_seq;
    localparam int ADDRW = 5;
    localparam int MAXS  = 1 << ADDRW;
    localparam int W     = 48;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    convolution_seq_if #(.ADDRW(ADDRW)) bus ();

    convolution_seq #(.ADDRW(ADDRW), .RD_LAT(1)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int vectors     = 0;
    int miscompares = 0;
    logic [W-1:0] exp_rd_q[$];
    logic [W-1:0] exp_first_q[$];
    logic [W-1:0] exp_wr_q[$];

    logic [7:0]  x_mem [MAXS];
    logic [7:0]  y_mem [MAXS];
    logic [7:0]  xd, yd;
    logic [31:0] acc;

    int   done_seen   = 0;
    int   busy_cycles = 0;
    logic rd_prev     = 1'b0;
    int   t_acc       = 0;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // memories with one-cycle read latency, and the accumulator the sequencer controls
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            xd  <= '0;
            yd  <= '0;
            acc <= '0;
        end else begin
            if (bus.rd_x) begin
                xd <= x_mem[bus.addr_x];
                yd <= y_mem[bus.addr_y];
            end
            if (bus.acc_en) begin
                acc <= (bus.acc_first ? 32'd0 : acc) + 32'(xd) * 32'(yd);
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rstn) begin
            rd_prev <= 1'b0;
        end else begin
            check("acc_en_latency", W'(bus.acc_en), W'(rd_prev));
            rd_prev <= bus.rd_x && !bus.abort;
            if (bus.rd_x) begin
                if (exp_rd_q.size() == 0) check("rd_x_unexpected", W'(1), W'(0));
                else check("rd_addr", W'({bus.addr_x, bus.addr_y}), exp_rd_q.pop_front());
            end
            if (bus.acc_en) begin
                if (exp_first_q.size() == 0) check("acc_en_unexpected", W'(1), W'(0));
                else check("acc_first", W'(bus.acc_first), exp_first_q.pop_front());
            end else begin
                check("acc_first_idle", W'(bus.acc_first), W'(0));
            end
            if (bus.wr_z) begin
                if (exp_wr_q.size() == 0) check("wr_z_unexpected", W'(1), W'(0));
                else check("wr_addr_z_value", W'({bus.addr_z, acc}), exp_wr_q.pop_front());
            end
            if (bus.done) done_seen++;
            if (bus.busy) busy_cycles++;
        end
    end

    // ---------------- reference model ----------------
    task automatic push_model(input int sx, input int sy);
        if (sx > 0 && sy > 0) begin
            for (int n = 0; n <= sx + sy - 2; n++) begin
                int klo;
                int khi;
                logic [31:0] z;
                logic [ADDRW-1:0] ka;
                logic [ADDRW-1:0] kb;
                logic [ADDRW:0] na;
                klo = (n - sy + 1 > 0) ? n - sy + 1 : 0;
                khi = (n < sx - 1) ? n : sx - 1;
                z = 0;
                for (int k = klo; k <= khi; k++) begin
                    ka = k[ADDRW-1:0];
                    kb = ADDRW'(n - k);
                    exp_rd_q.push_back(W'({ka, kb}));
                    exp_first_q.push_back(W'(k == klo));
                    z = z + 32'(x_mem[k]) * 32'(y_mem[n - k]);
                end
                na = n[ADDRW:0];
                exp_wr_q.push_back(W'({na, z}));
            end
        end
    endtask

    task automatic flush_model();
        exp_rd_q.delete();
        exp_first_q.delete();
        exp_wr_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic fill_random();
        for (int i = 0; i < MAXS; i++) begin
            x_mem[i] = 8'($urandom_range(0, 255));
            y_mem[i] = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic issue_start(input int sx, input int sy);
        @(posedge clk);
        #1;
        done_seen   = 0;
        busy_cycles = 0;
        bus.size_x  = sx[ADDRW:0];
        bus.size_y  = sy[ADDRW:0];
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        t_acc     = cyc;
    endtask

    task automatic wait_done(input int sx, input int sy);
        int exp_lat;
        int lim;
        exp_lat = (sx == 0 || sy == 0) ? 1 : sx * sy + 3;
        lim     = exp_lat + 20;
        while (!bus.done && (cyc - t_acc + 1) < lim) begin
            @(posedge clk);
            #1;
        end
        check("done_latency", W'(cyc - t_acc + 1), W'(exp_lat));
        @(posedge clk);
        #1;
        check("idle_after_done", W'({bus.busy, bus.done, bus.state_dbg}), W'(0));
        check("done_pulses", W'(done_seen), W'(1));
        check("busy_cycles", W'(busy_cycles), W'(exp_lat));
        check("queues_drained", W'(exp_rd_q.size() + exp_first_q.size() + exp_wr_q.size()), W'(0));
        flush_model();
    endtask

    task automatic run_op(input int sx, input int sy);
        push_model(sx, sy);
        issue_start(sx, sy);
        wait_done(sx, sy);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        bus.size_x = '0;
        bus.size_y = '0;
        #12;
        check("reset_strobes", W'({bus.rd_x, bus.acc_en, bus.acc_first, bus.wr_z, bus.busy, bus.done}), W'(0));
        check("reset_addrs", W'({bus.addr_x, bus.addr_y, bus.addr_z, bus.state_dbg}), W'(0));
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // small worked example: Z = {1,3,5,3}
        fill_random();
        x_mem[0] = 8'd1; x_mem[1] = 8'd2; x_mem[2] = 8'd3;
        y_mem[0] = 8'd1; y_mem[1] = 8'd1;
        run_op(3, 2);

        // single term: Z = 35
        x_mem[0] = 8'd7;
        y_mem[0] = 8'd5;
        run_op(1, 1);

        // maximum sizes, all ones
        for (int i = 0; i < MAXS; i++) begin
            x_mem[i] = 8'd1;
            y_mem[i] = 8'd1;
        end
        run_op(MAXS, MAXS);

        // empty operands
        run_op(0, 4);
        run_op(4, 0);

        // start together with abort in IDLE: nothing happens
        @(posedge clk);
        #1;
        bus.size_x = 6'd3;
        bus.size_y = 6'd3;
        bus.start  = 1'b1;
        bus.abort  = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("start_abort_idle", W'({bus.busy, bus.rd_x, bus.state_dbg}), W'(0));

        // abort three cycles into a run, then a clean run
        fill_random();
        push_model(3, 2);
        issue_start(3, 2);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        check("abort_strobes", W'({bus.rd_x, bus.acc_en, bus.acc_first, bus.wr_z}), W'(0));
        check("abort_idle", W'({bus.busy, bus.done, bus.state_dbg}), W'(0));
        flush_model();
        done_seen = 0;
        repeat (10) @(posedge clk);
        #1;
        check("abort_no_done", W'(done_seen), W'(0));
        run_op(3, 2);

        // second start while busy is ignored
        fill_random();
        push_model(4, 3);
        issue_start(4, 3);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        bus.size_x = 6'd2;
        bus.size_y = 6'd2;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(4, 3);

        // asynchronous reset in the middle of a run
        fill_random();
        push_model(5, 5);
        issue_start(5, 5);
        repeat (6) @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        check("midrun_reset_strobes", W'({bus.rd_x, bus.acc_en, bus.acc_first, bus.wr_z, bus.busy, bus.done}), W'(0));
        check("midrun_reset_addrs", W'({bus.addr_x, bus.addr_y, bus.addr_z, bus.state_dbg}), W'(0));
        flush_model();
        done_seen = 0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("after_reset_idle", W'({bus.busy, bus.state_dbg}), W'(0));
        check("reset_no_done", W'(done_seen), W'(0));

        // randomized sizes and data
        for (int r = 0; r < 24; r++) begin
            int sx;
            int sy;
            fill_random();
            if ($urandom_range(0, 5) == 0) begin
                sx = $urandom_range(0, MAXS);
                sy = $urandom_range(0, MAXS);
            end else begin
                sx = $urandom_range(0, 10);
                sy = $urandom_range(0, 10);
            end
            run_op(sx, sy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        miscompares++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
